// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register: single-step shift/rotate/load/clear plus a
// burst engine that repeats one shift-class operation amt times.
module univ_shift_reg #(
  parameter int                WIDTH   = 8,
  parameter logic [WIDTH-1:0]  RST_VAL = {WIDTH{1'b0}},
  localparam int               AW      = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AW-1:0]    amt,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHL  = 3'b001;
  localparam logic [2:0] M_SHR  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_ROTL = 3'b100;
  localparam logic [2:0] M_ROTR = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  // Handshake: start is sampled only in IDLE; busy is high for every cycle the
  // engine is in BURST; done pulses for one cycle, coincident with the first
  // cycle q carries the final burst result.
  state_t          state;
  logic [2:0]      bmode;
  logic [AW-1:0]   cnt;

  function automatic logic is_shift(input logic [2:0] m);
    return (m == M_SHL) || (m == M_SHR) || (m == M_ROTL) ||
           (m == M_ROTR) || (m == M_ASR);
  endfunction

  function automatic logic [WIDTH-1:0] step(input logic [2:0]       m,
                                            input logic [WIDTH-1:0] cur,
                                            input logic [WIDTH-1:0] ld,
                                            input logic             sl,
                                            input logic             sr);
    logic [WIDTH-1:0] nxt;
    nxt = cur;
    case (m)
      M_HOLD: nxt = cur;
      M_SHL:  nxt = {cur[WIDTH-2:0], sr};
      M_SHR:  nxt = {sl, cur[WIDTH-1:1]};
      M_LOAD: nxt = ld;
      M_ROTL: nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
      M_ROTR: nxt = {cur[0], cur[WIDTH-1:1]};
      M_ASR:  nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
      M_CLR:  nxt = {WIDTH{1'b0}};
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= RST_VAL;
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
      bmode <= M_HOLD;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_shift(mode)) begin
              if (amt != '0) begin
                // First step lands on the accepting edge; cnt holds steps still to go.
                q     <= step(mode, q, d, sin_l, sin_r);
                bmode <= mode;
                cnt   <= amt - AW'(1);
                if (amt == AW'(1)) begin
                  done <= 1'b1;
                end else begin
                  state <= BURST;
                  busy  <= 1'b1;
                end
              end else begin
                done <= 1'b1;
              end
            end else begin
              q    <= step(mode, q, d, sin_l, sin_r);
              done <= 1'b1;
            end
          end else if (en) begin
            q <= step(mode, q, d, sin_l, sin_r);
          end
        end
        BURST: begin
          q   <= step(bmode, q, d, sin_l, sin_r);
          cnt <= cnt - AW'(1);
          if (cnt == AW'(1)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8, RST_VAL=A5): table of single-step
// vectors followed by hand-written burst, back-to-back and reset-abort sequences.
module tb_univ_shift_reg;

  localparam int         WIDTH = 8;
  localparam int         AW    = $clog2(WIDTH+1);
  localparam logic [7:0] RV    = 8'hA5;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHL  = 3'b001;
  localparam logic [2:0] M_SHR  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_ROTL = 3'b100;
  localparam logic [2:0] M_ROTR = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  logic             clk = 1'b0;
  logic             rst, en, start, sin_l, sin_r;
  logic [2:0]       mode;
  logic [AW-1:0]    amt;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             sout_l, sout_r, busy, done;

  int n_pass  = 0;
  int n_total = 0;

  univ_shift_reg #(.WIDTH(WIDTH), .RST_VAL(RV)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .mode(mode), .amt(amt),
    .d(d), .sin_l(sin_l), .sin_r(sin_r), .q(q), .sout_l(sout_l),
    .sout_r(sout_r), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sin_l;
    logic       sin_r;
    logic [7:0] exp_q;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Advance one rising edge, then settle 1 time unit before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b0; start = 1'b0; mode = M_HOLD; amt = '0; d = '0;
    sin_l = 1'b0; sin_r = 1'b0;
  endtask

  task automatic load(input logic [7:0] val);
    en = 1'b1; start = 1'b0; mode = M_LOAD; d = val;
    tick();
    en = 1'b0;
  endtask

  initial begin
    int seen_done;
    int cyc;

    vecs[0]  = '{1'b1, M_CLR,  8'hFF, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, M_LOAD, 8'h96, 1'b0, 1'b0, 8'h96};
    vecs[2]  = '{1'b1, M_SHL,  8'h00, 1'b0, 1'b1, 8'h2D};
    vecs[3]  = '{1'b1, M_SHR,  8'h00, 1'b0, 1'b1, 8'h16};
    vecs[4]  = '{1'b1, M_LOAD, 8'h96, 1'b0, 1'b0, 8'h96};
    vecs[5]  = '{1'b1, M_ASR,  8'h00, 1'b0, 1'b0, 8'hCB};
    vecs[6]  = '{1'b1, M_LOAD, 8'h96, 1'b0, 1'b0, 8'h96};
    vecs[7]  = '{1'b1, M_ROTL, 8'h00, 1'b0, 1'b0, 8'h2D};
    vecs[8]  = '{1'b1, M_LOAD, 8'h96, 1'b0, 1'b0, 8'h96};
    vecs[9]  = '{1'b1, M_ROTR, 8'h00, 1'b0, 1'b0, 8'h4B};
    vecs[10] = '{1'b1, M_HOLD, 8'hFF, 1'b1, 1'b1, 8'h4B};
    vecs[11] = '{1'b1, M_HOLD, 8'hFF, 1'b1, 1'b1, 8'h4B};
    vecs[12] = '{1'b1, M_HOLD, 8'hFF, 1'b1, 1'b1, 8'h4B};
    vecs[13] = '{1'b1, M_SHR,  8'h00, 1'b1, 1'b0, 8'hA5};
    vecs[14] = '{1'b0, M_LOAD, 8'hFF, 1'b0, 1'b0, 8'hA5};
    vecs[15] = '{1'b1, M_CLR,  8'h00, 1'b0, 1'b0, 8'h00};

    // Reset
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("reset_q", q, RV);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);

    // Single-step table
    for (int i = 0; i < 16; i++) begin
      en = vecs[i].en; mode = vecs[i].mode; d = vecs[i].d;
      sin_l = vecs[i].sin_l; sin_r = vecs[i].sin_r;
      tick();
      chk($sformatf("step%0d_q", i), q, vecs[i].exp_q);
      chk($sformatf("step%0d_sout_l", i), sout_l, vecs[i].exp_q[7]);
      chk($sformatf("step%0d_sout_r", i), sout_r, vecs[i].exp_q[0]);
      chk($sformatf("step%0d_done", i), done, 1'b0);
      chk($sformatf("step%0d_busy", i), busy, 1'b0);
    end
    idle_inputs();

    // Burst ROTL x3 from 81 with LOAD/en noise during the burst
    load(8'h81);
    start = 1'b1; mode = M_ROTL; amt = AW'(3);
    tick();
    start = 1'b0; en = 1'b1; mode = M_LOAD; d = 8'hFF; amt = AW'(7);
    chk("b3_e1_q", q, 8'h03); chk("b3_e1_busy", busy, 1'b1); chk("b3_e1_done", done, 1'b0);
    tick();
    chk("b3_e2_q", q, 8'h06); chk("b3_e2_busy", busy, 1'b1); chk("b3_e2_done", done, 1'b0);
    tick();
    chk("b3_e3_q", q, 8'h0C); chk("b3_e3_busy", busy, 1'b0); chk("b3_e3_done", done, 1'b1);
    idle_inputs();
    tick();
    chk("b3_after_done", done, 1'b0); chk("b3_after_q", q, 8'h0C);

    // amt=0 shift-class start: no change, done pulse, never busy
    start = 1'b1; mode = M_SHL; amt = '0; sin_r = 1'b1;
    tick();
    start = 1'b0;
    chk("amt0_q", q, 8'h0C); chk("amt0_done", done, 1'b1); chk("amt0_busy", busy, 1'b0);
    tick();
    chk("amt0_done_clear", done, 1'b0);

    // amt=1 completes on the accepting edge
    start = 1'b1; mode = M_SHR; amt = AW'(1); sin_l = 1'b1;
    tick();
    start = 1'b0;
    chk("amt1_q", q, 8'h86); chk("amt1_done", done, 1'b1); chk("amt1_busy", busy, 0);
    load(8'h0C);

    // ROTL x2 with start held: ignored in BURST, accepted while done=1
    start = 1'b1; mode = M_ROTL; amt = AW'(2);
    tick();
    chk("bb_e1_q", q, 8'h18); chk("bb_e1_busy", busy, 1'b1);
    mode = M_SHL; amt = AW'(4); sin_r = 1'b1;
    tick();
    chk("bb_e2_q", q, 8'h30); chk("bb_e2_done", done, 1'b1); chk("bb_e2_busy", busy, 1'b0);
    tick();
    start = 1'b0;
    chk("bb_e3_q", q, 8'h61); chk("bb_e3_busy", busy, 1'b1); chk("bb_e3_done", done, 1'b0);
    tick();
    chk("bb_e4_q", q, 8'hC3);
    tick();
    chk("bb_e5_q", q, 8'h87); chk("bb_e5_done", done, 1'b0);
    tick();
    chk("bb_e6_q", q, 8'h0F); chk("bb_e6_done", done, 1'b1); chk("bb_e6_busy", busy, 1'b0);
    idle_inputs();

    // Count above WIDTH runs literally: ROTL x9 from 01 -> 02
    load(8'h01);
    start = 1'b1; mode = M_ROTL; amt = AW'(9);
    tick();
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("b9_steps", cyc, 9);
    chk("b9_q", q, 8'h02);
    idle_inputs();

    // Reset aborts a ROTR x5 burst from 01 after two steps
    load(8'h01);
    start = 1'b1; mode = M_ROTR; amt = AW'(5);
    tick();
    start = 1'b0;
    chk("abort_e1_q", q, 8'h80);
    tick();
    chk("abort_e2_q", q, 8'h40);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_q", q, RV); chk("abort_busy", busy, 1'b0); chk("abort_done", done, 1'b0);
    seen_done = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || busy) seen_done++;
    end
    chk("abort_no_done_later", seen_done, 0);
    chk("abort_q_hold", q, RV);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
